// File: rtl/perf_ovf_irq_ctrl.sv
// Performance counter overflow interrupt controller: each counter has an arm/pend FSM
// against a programmable threshold, a fixed-priority interrupt ID and a saturating crossing count.
module perf_ovf_irq_ctrl #(
  parameter int unsigned NumCounters = 6,
  parameter int unsigned CntWidth    = 64
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [NumCounters*CntWidth-1:0] counter_i,
  input  logic [NumCounters*CntWidth-1:0] threshold_i,
  input  logic [NumCounters-1:0]          irq_en_i,
  input  logic                            clear_we_i,
  input  logic [NumCounters-1:0]          clear_mask_i,
  input  logic                            irq_ack_i,
  output logic                            irq_o,
  output logic [2:0]                      irq_id_o,
  output logic [NumCounters-1:0]          ovf_status_o,
  output logic [15:0]                     irq_count_o
);

  typedef enum logic [1:0] {IDLE, ARMED, PEND, SPENT} state_e;

  state_e                 state_q [NumCounters];
  logic [NumCounters-1:0] pend;
  logic [NumCounters-1:0] hit;
  logic [NumCounters-1:0] thr_off;
  logic [NumCounters-1:0] clr;
  logic [NumCounters-1:0] fire;
  logic [NumCounters-1:0] active;
  logic [2:0]             irq_id;
  logic [16:0]            count_sum;
  logic [15:0]            irq_count_q;

  always_comb begin
    pend    = '0;
    hit     = '0;
    thr_off = '0;
    for (int unsigned i = 0; i < NumCounters; i++) begin
      pend[i]    = (state_q[i] == PEND);
      hit[i]     = counter_i[i*CntWidth +: CntWidth] >= threshold_i[i*CntWidth +: CntWidth];
      thr_off[i] = (threshold_i[i*CntWidth +: CntWidth] == '0);
    end
  end

  assign active = pend & irq_en_i;

  // Scan from the top so the lowest enabled pending index wins.
  always_comb begin
    irq_id = '0;
    for (int unsigned i = NumCounters; i > 0; i--) begin
      if (active[i-1]) irq_id = 3'(i - 1);
    end
  end

  assign irq_o        = |active;
  assign irq_id_o     = irq_id;
  assign ovf_status_o = pend;
  assign irq_count_o  = irq_count_q;

  // Clear and ack are OR-ed into one request, so a doubly-targeted counter is cleared once.
  always_comb begin
    clr       = '0;
    fire      = '0;
    count_sum = {1'b0, irq_count_q};
    for (int unsigned i = 0; i < NumCounters; i++) begin
      clr[i]    = pend[i] & ((clear_we_i & clear_mask_i[i]) |
                             (irq_ack_i & irq_o & (irq_id == 3'(i))));
      fire[i]   = (state_q[i] == ARMED) & hit[i] & ~thr_off[i];
      count_sum = count_sum + 17'(fire[i]);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < NumCounters; i++) state_q[i] <= IDLE;
      irq_count_q <= '0;
    end else begin
      for (int unsigned i = 0; i < NumCounters; i++) begin
        if (thr_off[i]) begin
          state_q[i] <= IDLE;
        end else begin
          unique case (state_q[i])
            IDLE:    state_q[i] <= hit[i] ? SPENT : ARMED;
            ARMED:   if (hit[i]) state_q[i] <= PEND;
            PEND:    if (clr[i]) state_q[i] <= hit[i] ? SPENT : ARMED;
            SPENT:   if (!hit[i]) state_q[i] <= ARMED;
            default: state_q[i] <= IDLE;
          endcase
        end
      end
      irq_count_q <= count_sum[16] ? 16'hFFFF : count_sum[15:0];
    end
  end

endmodule
